bt_cmd_ctrl: RTL and testbench
==============================

Name: bt_cmd_ctrl

Overview:
Parametrised successor to the single-bit Bluetooth control path. It receives 8N1 UART bytes from the Bluetooth module, decodes a small ASCII command set, and holds the player state: volume, song index across NUM_SONGS tracks, and pause. It also auto-advances to the next song when the decoder signals end of track. It sits between the rx pin and the mp3 player block, and drives its volume, song and pause inputs directly.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, UART bit rate; localparam BAUD_DIV = CLK_FREQ/BAUD
NUM_SONGS, 4, number of selectable tracks (2..10); localparam SONG_W = max(1, clog2(NUM_SONGS))
VOL_DEFAULT, 8'h20, per-channel attenuation loaded at reset
VOL_STEP, 8'h10, attenuation change per '+'/'-' command
ARG_TIMEOUT, CLK_FREQ/10, cycles allowed between a command byte and its argument byte

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  UART line from Bluetooth module, idle high, asynchronous to clk
i_FINISH  in  1  one-cycle pulse from the mp3 block at end of track
o_vol  out  16  VS10xx volume word {att,att}; 0x0000 is loudest, 0xFEFE is quietest
o_song  out  SONG_W  current track index
o_pause  out  1  1 = playback paused
o_song_change  out  1  one-cycle pulse whenever o_song is (re)loaded
o_cmd_err  out  1  one-cycle pulse on a framing error, unknown command, bad argument or timeout

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: att=VOL_DEFAULT, so o_vol={VOL_DEFAULT,VOL_DEFAULT}. o_song=0, o_pause=0, o_song_change=0, o_cmd_err=0, FSM=IDLE, UART rx=IDLE.
- rx passes through a 2-FF synchronizer. Its reset value is 1.
- UART rx:
  - A falling edge starts a frame. The start bit is re-checked at BAUD_DIV/2; if it is high, the frame is treated as a glitch and rx returns to idle.
  - The 8 data bits are sampled LSB first at the centre of each bit.
  - The stop bit is sampled at its centre. If it is high, rx_valid pulses for 1 cycle with rx_byte. If it is low, nothing is delivered and o_cmd_err pulses.
- Command FSM, IDLE state. On rx_valid:
  - 'P' (0x50): toggle o_pause.
  - 'N' (0x4E): o_song = (o_song==NUM_SONGS-1) ? 0 : o_song+1, and pulse o_song_change.
  - 'B' (0x42): o_song = (o_song==0) ? NUM_SONGS-1 : o_song-1, and pulse o_song_change.
  - '+' (0x2B): att = (att<VOL_STEP) ? 0 : att-VOL_STEP.
  - '-' (0x2D): att = min(att+VOL_STEP, 0xFE), computed in 9 bits.
  - 'S' (0x53): go to ARG_SONG.
  - 'V' (0x56): go to ARG_VOL.
  - Any other byte: pulse o_cmd_err; state is unchanged.
- ARG_SONG:
  - Byte '0'..'9' with value < NUM_SONGS: load o_song and pulse o_song_change, even if the value equals the current song (this restarts the track).
  - Any other byte: pulse o_cmd_err with no change.
  - Return to IDLE in both cases.
- ARG_VOL: any byte b sets att = (b>0xFE) ? 0xFE : b, then return to IDLE.
- Argument timeout: a counter is cleared on entry to ARG_*. If it reaches ARG_TIMEOUT, pulse o_cmd_err and go to IDLE; the argument is discarded.
- Latency: every output updates on the clock edge following the rx_valid cycle. o_song_change and o_cmd_err are high for exactly that one cycle.
- i_FINISH in IDLE or ARG_* advances o_song with wrap and pulses o_song_change. It does not change o_pause or the FSM state.
- i_FINISH in the same cycle as a decoded song-changing command: the command wins and i_FINISH is dropped, so there is a single update.
- i_FINISH in the same cycle as a non-song command: both take effect.
- Reset mid-frame or mid-argument returns everything to reset values immediately. A partial frame is lost.
- o_vol is registered. Both bytes always carry the same att.

Decomposition:
- Shared package bt_cmd_pkg holds:
  - command byte constants: CMD_PAUSE, CMD_NEXT, CMD_PREV, CMD_VOLUP, CMD_VOLDN, CMD_SONG, CMD_VOL
  - ASCII_0
  - VOL_ATT_MAX = 8'hFE
  - FSM state enum {IDLE, ARG_SONG, ARG_VOL}
- One sub-module, uart_rx_8n1 (parameters CLK_FREQ, BAUD). It contains the synchronizer and the bit FSM, and outputs rx_byte, rx_valid and frame_err.
- Command decode and state registers live in bt_cmd_ctrl.

Test Plan:
Sim with CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), NUM_SONGS=4, ARG_TIMEOUT=500.
1. Release reset -> o_vol=0x2020, o_song=0, o_pause=0, no pulses. Send 'P' -> o_pause=1; send 'P' again -> o_pause=0.
2. Send 'N' x4 -> o_song steps 1,2,3,0 with four single-cycle o_song_change pulses. Send 'B' from 0 -> o_song=3.
3. Send '+' three times from 0x20 -> att goes 0x10, 0x00, 0x00. Send 'V',0xFF -> o_vol=0xFEFE. Send '-' -> stays 0xFEFE.
4. Send 'S','2' -> o_song=2 with a pulse. Send 'S','7' -> o_cmd_err pulses, o_song stays 2. Send 'S' then idle 600 cycles -> o_cmd_err after 500, FSM in IDLE. Next 'N' -> o_song=3.
5. Send 0x4E with stop bit 0 -> o_cmd_err pulses, o_song unchanged. Send 'X' -> o_cmd_err pulses.
6. Assert i_FINISH on the same cycle rx_valid delivers 'N' with o_song=1 -> o_song=2, exactly one pulse. i_FINISH alone at o_song=3 -> o_song=0. Assert rst_n low mid-byte -> all outputs at reset values.

Source files
------------

// File: rtl/bt_cmd_pkg.sv
// Shared constants and state types for the Bluetooth command controller.
package bt_cmd_pkg;

    // ASCII command bytes from the Bluetooth app
    localparam logic [7:0] CMD_PAUSE   = 8'h50;  // 'P'
    localparam logic [7:0] CMD_NEXT    = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_PREV    = 8'h42;  // 'B'
    localparam logic [7:0] CMD_VOLUP   = 8'h2B;  // '+'
    localparam logic [7:0] CMD_VOLDN   = 8'h2D;  // '-'
    localparam logic [7:0] CMD_SONG    = 8'h53;  // 'S'
    localparam logic [7:0] CMD_VOL     = 8'h56;  // 'V'
    localparam logic [7:0] ASCII_0     = 8'h30;  // '0'

    // Largest usable VS10xx attenuation (0xFF means analog power-down)
    localparam logic [7:0] VOL_ATT_MAX = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        ARG_SONG,
        ARG_VOL
    } cmd_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch rejection,
// centre-of-bit sampling, one-cycle byte/framing-error strobes.
module uart_rx_8n1
    import bt_cmd_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             rx_s;
    rx_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    // State register: synchronizer, edge history, bit FSM and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            st_q   <= RX_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            prev_q <= rx_s;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            vld_q  <= vld_d;
            ferr_q <= ferr_d;
        end
    end

    // Next state: bit timing counts from the detected falling edge
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + CNT_W'(1);
        bit_d  = bit_q;
        sh_d   = sh_q;
        vld_d  = 1'b0;
        ferr_d = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s && prev_q) st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // Line back high at mid start bit: a glitch, not a frame
                    st_d  = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    if (rx_s) vld_d  = 1'b1;
                    else      ferr_d = 1'b1;
                end
            end
            default: begin
                st_d  = RX_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Outputs straight from registers
    always_comb begin
        rx_byte   = sh_q;
        rx_valid  = vld_q;
        frame_err = ferr_q;
    end

endmodule

// File: rtl/bt_cmd_ctrl.sv
// Bluetooth command controller: decodes ASCII commands from the UART and
// holds volume, song index and pause state for the mp3 player block.
module bt_cmd_ctrl
    import bt_cmd_pkg::*;
#(
    parameter int         CLK_FREQ    = 100_000_000,
    parameter int         BAUD        = 9600,
    parameter int         NUM_SONGS   = 4,
    parameter logic [7:0] VOL_DEFAULT = 8'h20,
    parameter logic [7:0] VOL_STEP    = 8'h10,
    parameter int         ARG_TIMEOUT = CLK_FREQ / 10,
    localparam int        SONG_W      = ($clog2(NUM_SONGS) < 1) ? 1 : $clog2(NUM_SONGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              i_FINISH,
    output logic [15:0]       o_vol,
    output logic [SONG_W-1:0] o_song,
    output logic              o_pause,
    output logic              o_song_change,
    output logic              o_cmd_err
);

    localparam logic [SONG_W-1:0] SONG_LAST   = SONG_W'(NUM_SONGS - 1);
    localparam logic [7:0]        NUM_SONGS_B = 8'(NUM_SONGS);
    localparam int                TMR_W       = $clog2(ARG_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(ARG_TIMEOUT - 1);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              frame_err;

    cmd_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        att_q, att_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              pause_q, pause_d;
    logic              chg_q, chg_d;
    logic              err_q, err_d;

    logic [SONG_W-1:0] next_song;
    logic [8:0]        vol_sum;
    logic [7:0]        digit;
    logic              song_cmd;

    uart_rx_8n1 #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    assign next_song = (song_q == SONG_LAST) ? '0 : song_q + SONG_W'(1);
    assign vol_sum   = {1'b0, att_q} + {1'b0, VOL_STEP};
    assign digit     = rx_byte - ASCII_0;

    // State register: command FSM, argument timer and player state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            att_q   <= VOL_DEFAULT;
            song_q  <= '0;
            pause_q <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            att_q   <= att_d;
            song_q  <= song_d;
            pause_q <= pause_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    // Next state: command decode, argument handling and end-of-track advance
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        att_d    = att_q;
        song_d   = song_q;
        pause_d  = pause_q;
        chg_d    = 1'b0;
        err_d    = frame_err;
        song_cmd = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_byte)
                        CMD_PAUSE: pause_d = ~pause_q;
                        CMD_NEXT: begin
                            song_d   = next_song;
                            chg_d    = 1'b1;
                            song_cmd = 1'b1;
                        end
                        CMD_PREV: begin
                            song_d   = (song_q == '0) ? SONG_LAST : song_q - SONG_W'(1);
                            chg_d    = 1'b1;
                            song_cmd = 1'b1;
                        end
                        CMD_VOLUP: att_d = (att_q < VOL_STEP) ? 8'h00 : att_q - VOL_STEP;
                        CMD_VOLDN: att_d = (vol_sum > {1'b0, VOL_ATT_MAX}) ? VOL_ATT_MAX
                                                                            : vol_sum[7:0];
                        CMD_SONG: begin
                            state_d = ARG_SONG;
                            tmr_d   = '0;
                        end
                        CMD_VOL: begin
                            state_d = ARG_VOL;
                            tmr_d   = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ARG_SONG: begin
                if (rx_valid) begin
                    state_d = IDLE;
                    // Reloading the current index is deliberate: it restarts the track
                    if (rx_byte >= ASCII_0 && digit < NUM_SONGS_B) begin
                        song_d   = digit[SONG_W-1:0];
                        chg_d    = 1'b1;
                        song_cmd = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ARG_VOL: begin
                if (rx_valid) begin
                    state_d = IDLE;
                    att_d   = (rx_byte > VOL_ATT_MAX) ? VOL_ATT_MAX : rx_byte;
                end else if (tmr_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A decoded song command in the same cycle supersedes end-of-track
        if (i_FINISH && !song_cmd) begin
            song_d = next_song;
            chg_d  = 1'b1;
        end
    end

    // Outputs: both volume bytes carry the same attenuation
    always_comb begin
        o_vol         = {att_q, att_q};
        o_song        = song_q;
        o_pause       = pause_q;
        o_song_change = chg_q;
        o_cmd_err     = err_q;
    end

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed bench for bt_cmd_ctrl at BAUD_DIV=10, four songs, 500-cycle timeout.
module tb_bt_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        i_FINISH = 1'b0;
    logic [15:0] o_vol;
    logic [1:0]  o_song;
    logic        o_pause;
    logic        o_song_change;
    logic        o_cmd_err;

    int n_assert = 0;
    int n_fail   = 0;
    int chg_cnt  = 0;
    int err_cnt  = 0;
    int chg_len  = 0;
    int chg_max  = 0;
    int err_len  = 0;
    int err_max  = 0;
    int c0, e0, k_wait;

    always #5 clk = ~clk;

    bt_cmd_ctrl #(
        .CLK_FREQ    (1_000_000),
        .BAUD        (100_000),
        .NUM_SONGS   (4),
        .VOL_DEFAULT (8'h20),
        .VOL_STEP    (8'h10),
        .ARG_TIMEOUT (500)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .i_FINISH      (i_FINISH),
        .o_vol         (o_vol),
        .o_song        (o_song),
        .o_pause       (o_pause),
        .o_song_change (o_song_change),
        .o_cmd_err     (o_cmd_err)
    );

    // Pulse counters and longest-run trackers, sampled on the inactive edge
    always @(negedge clk) begin
        if (o_song_change) begin
            chg_cnt++;
            chg_len++;
            if (chg_len > chg_max) chg_max = chg_len;
        end else begin
            chg_len = 0;
        end
        if (o_cmd_err) begin
            err_cnt++;
            err_len++;
            if (err_len > err_max) err_max = err_len;
        end else begin
            err_len = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame (10 clocks per bit), then a short idle gap
    task automatic send(input logic [7:0] b, input logic stop);
        @(posedge clk);
        rx = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(posedge clk);
        end
        rx = stop;
        repeat (10) @(posedge clk);
        rx = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    // Frame whose delivery cycle coincides with an end-of-track pulse
    task automatic send_with_finish(input logic [7:0] b);
        fork
            send(b, 1'b1);
            begin
                k_wait = 0;
                while (u_dut.rx_valid !== 1'b1 && k_wait < 300) begin
                    @(negedge clk);
                    k_wait++;
                end
                chk("rx_valid_seen", 32'(k_wait < 300), 32'd1);
                i_FINISH = 1'b1;
                @(negedge clk);
                i_FINISH = 1'b0;
            end
        join
    endtask

    initial begin
        // Reset
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_vol",   32'(o_vol), 32'h2020);
        chk("rst_song",  32'(o_song), 32'd0);
        chk("rst_pause", 32'(o_pause), 32'd0);
        chk("rst_chg",   32'(o_song_change), 32'd0);
        chk("rst_err",   32'(o_cmd_err), 32'd0);

        // Pause toggling
        send(8'h50, 1'b1);
        chk("pause_on", 32'(o_pause), 32'd1);
        send(8'h50, 1'b1);
        chk("pause_off", 32'(o_pause), 32'd0);

        // Next x4 with wrap, then previous from 0
        c0 = chg_cnt;
        send(8'h4E, 1'b1); chk("next1", 32'(o_song), 32'd1);
        send(8'h4E, 1'b1); chk("next2", 32'(o_song), 32'd2);
        send(8'h4E, 1'b1); chk("next3", 32'(o_song), 32'd3);
        send(8'h4E, 1'b1); chk("next_wrap", 32'(o_song), 32'd0);
        chk("next_pulses", 32'(chg_cnt - c0), 32'd4);
        chk("chg_width", 32'(chg_max), 32'd1);
        send(8'h42, 1'b1); chk("prev_wrap", 32'(o_song), 32'd3);

        // Volume steps and clamps
        send(8'h2B, 1'b1); chk("volup1", 32'(o_vol), 32'h1010);
        send(8'h2B, 1'b1); chk("volup2", 32'(o_vol), 32'h0000);
        send(8'h2B, 1'b1); chk("volup_floor", 32'(o_vol), 32'h0000);
        send(8'h2D, 1'b1); chk("voldn_from0", 32'(o_vol), 32'h1010);
        send(8'h56, 1'b1);
        send(8'hFF, 1'b1); chk("vol_arg_clamp", 32'(o_vol), 32'hFEFE);
        send(8'h2D, 1'b1); chk("voldn_ceiling", 32'(o_vol), 32'hFEFE);

        // Song argument: valid, out of range, timeout
        c0 = chg_cnt;
        send(8'h53, 1'b1);
        send(8'h32, 1'b1);
        chk("song_arg", 32'(o_song), 32'd2);
        chk("song_arg_pulse", 32'(chg_cnt - c0), 32'd1);
        e0 = err_cnt;
        send(8'h53, 1'b1);
        send(8'h37, 1'b1);
        chk("song_bad_err", 32'(err_cnt - e0), 32'd1);
        chk("song_bad_keep", 32'(o_song), 32'd2);
        e0 = err_cnt;
        send(8'h53, 1'b1);
        repeat (600) @(negedge clk);
        chk("timeout_err", 32'(err_cnt - e0), 32'd1);
        send(8'h4E, 1'b1);
        chk("after_timeout_next", 32'(o_song), 32'd3);

        // Framing error and unknown command
        e0 = err_cnt;
        send(8'h4E, 1'b0);
        chk("frame_err", 32'(err_cnt - e0), 32'd1);
        chk("frame_err_keep", 32'(o_song), 32'd3);
        e0 = err_cnt;
        send(8'h58, 1'b1);
        chk("unknown_err", 32'(err_cnt - e0), 32'd1);
        chk("err_width", 32'(err_max), 32'd1);

        // End-of-track interactions
        send(8'h53, 1'b1);
        send(8'h31, 1'b1);
        chk("song_arg1", 32'(o_song), 32'd1);
        c0 = chg_cnt;
        send_with_finish(8'h4E);
        chk("finish_vs_next", 32'(o_song), 32'd2);
        chk("finish_vs_next_pulse", 32'(chg_cnt - c0), 32'd1);
        send(8'h4E, 1'b1);
        c0 = chg_cnt;
        i_FINISH = 1'b1;
        @(negedge clk);
        i_FINISH = 1'b0;
        repeat (2) @(negedge clk);
        chk("finish_wrap", 32'(o_song), 32'd0);
        chk("finish_pulse", 32'(chg_cnt - c0), 32'd1);
        send_with_finish(8'h50);
        chk("finish_with_pause_song", 32'(o_song), 32'd1);
        chk("finish_with_pause_p", 32'(o_pause), 32'd1);
        send(8'h56, 1'b1);
        send(8'h40, 1'b1);
        chk("vol_arg", 32'(o_vol), 32'h4040);

        // Reset in the middle of a frame
        @(posedge clk);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_vol",   32'(o_vol), 32'h2020);
        chk("midrst_song",  32'(o_song), 32'd0);
        chk("midrst_pause", 32'(o_pause), 32'd0);
        repeat (3) @(posedge clk);
        rx = 1'b1;
        rst_n = 1'b1;
        e0 = err_cnt;
        c0 = chg_cnt;
        repeat (200) @(negedge clk);
        chk("postrst_no_err", 32'(err_cnt - e0), 32'd0);
        chk("postrst_no_chg", 32'(chg_cnt - c0), 32'd0);
        chk("postrst_vol", 32'(o_vol), 32'h2020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
